// File: rtl/ps2_keymap_pkg.sv
// Shared types for the PS/2 scancode-to-button mapper: table entry, key event, FSM states.
package ps2_keymap_pkg;

  localparam int unsigned KeyToggle  = 10;
  localparam int unsigned KeyPressed = 9;
  localparam int unsigned KeyExt     = 8;

  // Wide enough for the largest supported button count (32).
  localparam int unsigned BtnIdxW = 5;

  typedef struct packed {
    logic               valid;
    logic               extwild;
    logic [8:0]         code;
    logic [BtnIdxW-1:0] btn;
  } map_entry_t;

  typedef struct packed {
    logic       pressed;
    logic [8:0] code;
  } key_event_t;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  function automatic logic entry_match(map_entry_t e, logic [8:0] code);
    return e.valid && (e.code[7:0] == code[7:0]) && (e.extwild || (e.code[8] == code[8]));
  endfunction

endpackage

// File: rtl/ps2_keymap_if.sv
// Keyboard event, mapping-table write port and button outputs of ps2_keymap.
interface ps2_keymap_if #(
  parameter int unsigned NUM_KEYS = 32,
  parameter int unsigned NUM_BTNS = 16
);
  logic [10:0]                 ps2_key;
  logic                        release_all;
  logic                        map_wr;
  logic [$clog2(NUM_KEYS)-1:0] map_addr;
  logic                        map_valid;
  logic                        map_extwild;
  logic [8:0]                  map_code;
  logic [$clog2(NUM_BTNS)-1:0] map_btn;
  logic [NUM_BTNS-1:0]         btn;
  logic                        busy;
  logic                        overflow;

  modport master (
    output ps2_key, release_all, map_wr, map_addr, map_valid, map_extwild, map_code, map_btn,
    input  btn, busy, overflow
  );

  modport slave (
    input  ps2_key, release_all, map_wr, map_addr, map_valid, map_extwild, map_code, map_btn,
    output btn, busy, overflow
  );
endinterface

// File: rtl/ps2_keymap_stretch.sv
// Per-button minimum-width stretcher; only buttons selected by PULSE_MASK get a counter.
module ps2_keymap_stretch #(
  parameter int unsigned         NUM_BTNS     = 16,
  parameter logic [NUM_BTNS-1:0] PULSE_MASK   = '0,
  parameter int unsigned         PULSE_CYCLES = 1000000
) (
  input  logic                clk_sys,
  input  logic                RESET,
  input  logic                clear,
  input  logic [NUM_BTNS-1:0] press,
  input  logic [NUM_BTNS-1:0] held,
  output logic [NUM_BTNS-1:0] btn
);
  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);

  logic unused_ctrl;
  assign unused_ctrl = ^{clk_sys, RESET, clear};

  for (genvar i = 0; i < int'(NUM_BTNS); i++) begin : g_btn
    if (PULSE_MASK[i]) begin : g_pulse
      logic [CntW-1:0] cnt_q;

      always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (press[i]) begin
          cnt_q <= CntW'(PULSE_CYCLES);
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end

      assign btn[i] = held[i] | (cnt_q != '0);
    end else begin : g_plain
      logic unused_press;
      assign unused_press = press[i];
      assign btn[i]       = held[i];
    end
  end

endmodule

// File: rtl/ps2_keymap.sv
// Maps MiSTer ps2_key toggle events onto a registered button vector through a writable
// table, scanned one entry per cycle, with a 1-deep pending slot for events during a scan.
module ps2_keymap
  import ps2_keymap_pkg::*;
#(
  parameter int unsigned         NUM_KEYS     = 32,
  parameter int unsigned         NUM_BTNS     = 16,
  parameter logic [NUM_BTNS-1:0] PULSE_MASK   = '0,
  parameter int unsigned         PULSE_CYCLES = 1000000
) (
  input logic         clk_sys,
  input logic         RESET,
  ps2_keymap_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_KEYS);

  map_entry_t          table_q [NUM_KEYS];
  map_entry_t          scan_entry;
  key_event_t          cur_q, pend_q, new_ev;
  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q;
  logic                init_q, old_toggle_q, pend_full_q, overflow_q;
  logic                event_v, scan_match, scan_last;
  logic [NUM_BTNS-1:0] btn_state_q, hit, press;

  assign new_ev     = '{pressed: bus.ps2_key[KeyPressed], code: bus.ps2_key[KeyExt:0]};
  assign event_v    = !init_q && (bus.ps2_key[KeyToggle] != old_toggle_q);
  assign scan_entry = table_q[idx_q];
  assign scan_match = (state_q == StScan) && entry_match(scan_entry, cur_q.code);
  assign scan_last  = (idx_q == IdxW'(NUM_KEYS - 1));

  // Out-of-range button indices simply never hit any bit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      hit[i] = scan_match && (scan_entry.btn == BtnIdxW'(i));
    end
  end
  assign press = hit & {NUM_BTNS{cur_q.pressed}};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pend_full_q || event_v) state_d = StScan;
      StScan:  if (scan_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.release_all) state_d = StIdle;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      init_q       <= 1'b1;
      old_toggle_q <= 1'b0;
      pend_full_q  <= 1'b0;
      overflow_q   <= 1'b0;
      cur_q        <= '0;
      pend_q       <= '0;
      btn_state_q  <= '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) table_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b0;
      old_toggle_q <= bus.ps2_key[KeyToggle];
      if (bus.map_wr && (int'(bus.map_addr) < int'(NUM_KEYS))) begin
        table_q[bus.map_addr] <= '{valid:   bus.map_valid,
                                   extwild: bus.map_extwild,
                                   code:    bus.map_code,
                                   btn:     BtnIdxW'(bus.map_btn)};
      end
      if (bus.release_all) begin
        btn_state_q <= '0;
        pend_full_q <= 1'b0;
      end else begin
        for (int i = 0; i < int'(NUM_BTNS); i++) begin
          if (hit[i]) btn_state_q[i] <= cur_q.pressed;
        end
        if (state_q == StIdle) begin
          if (pend_full_q || event_v) begin
            idx_q <= '0;
            cur_q <= pend_full_q ? pend_q : new_ev;
          end
          // A new event arriving while the slot drains takes the slot's place.
          if (pend_full_q) begin
            pend_full_q <= event_v;
            pend_q      <= new_ev;
          end
        end else begin
          if (!scan_last) idx_q <= idx_q + 1'b1;
          if (event_v) begin
            pend_q      <= new_ev;
            pend_full_q <= 1'b1;
            if (pend_full_q) overflow_q <= 1'b1;
          end
        end
      end
    end
  end

  ps2_keymap_stretch #(
    .NUM_BTNS    (NUM_BTNS),
    .PULSE_MASK  (PULSE_MASK),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_stretch (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .clear  (bus.release_all),
    .press  (press),
    .held   (btn_state_q),
    .btn    (bus.btn)
  );

  assign bus.busy     = (state_q == StScan);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_keymap.sv
// Directed and randomized checks of ps2_keymap against a table-lookup model of key events.
module tb_ps2_keymap;
  localparam int unsigned NK = 8;
  localparam int unsigned NB = 12;
  localparam int unsigned PC = 20;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;

  ps2_keymap_if #(.NUM_KEYS(NK), .NUM_BTNS(NB)) bus ();

  ps2_keymap #(
    .NUM_KEYS    (NK),
    .NUM_BTNS    (NB),
    .PULSE_MASK  (12'h080),
    .PULSE_CYCLES(PC)
  ) dut (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  logic          m_valid [NK];
  logic          m_ext   [NK];
  logic [8:0]    m_code  [NK];
  int            m_btn   [NK];
  logic [NB-1:0] m_state;
  logic [8:0]    pool    [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic model_clear();
    for (int k = 0; k < NK; k++) begin
      m_valid[k] = 1'b0;
      m_ext[k]   = 1'b0;
      m_code[k]  = '0;
      m_btn[k]   = 0;
    end
    m_state = '0;
  endtask

  task automatic model_event(input bit p, input logic [8:0] code);
    for (int k = 0; k < NK; k++) begin
      if (m_valid[k] && (m_code[k][7:0] == code[7:0]) && (m_ext[k] || (m_code[k][8] == code[8]))
          && (m_btn[k] < NB)) begin
        m_state[m_btn[k]] = p;
      end
    end
  endtask

  task automatic map_write(input int addr, input bit v, input bit x, input logic [8:0] code,
                           input int b);
    bus.map_wr      = 1'b1;
    bus.map_addr    = 3'(addr);
    bus.map_valid   = v;
    bus.map_extwild = x;
    bus.map_code    = code;
    bus.map_btn     = 4'(b);
    tick();
    bus.map_wr = 1'b0;
    m_valid[addr] = v;
    m_ext[addr]   = x;
    m_code[addr]  = code;
    m_btn[addr]   = b;
  endtask

  task automatic drive_event(input bit p, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], p, code};
  endtask

  task automatic send(input bit p, input logic [8:0] code);
    drive_event(p, code);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n, hi;
    bit  seen, hit, rise;
    int  r;
    bit  p;
    logic [8:0] c;

    pool[0] = 9'h029; pool[1] = 9'h014; pool[2] = 9'h075; pool[3] = 9'h175;
    pool[4] = 9'h02E; pool[5] = 9'h01C; pool[6] = 9'h11C; pool[7] = 9'h033;

    bus.ps2_key     = 11'h400;
    bus.release_all = 1'b0;
    bus.map_wr      = 1'b0;
    bus.map_addr    = '0;
    bus.map_valid   = 1'b0;
    bus.map_extwild = 1'b0;
    bus.map_code    = '0;
    bus.map_btn     = '0;
    model_clear();

    ticks(3);
    check_eq("rst_btn", 32'(bus.btn), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_overflow", 32'(bus.overflow), 0);
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= bus.busy;
    end
    check_eq("no_event_after_reset", 32'(seen), 0);

    // Basic press/release with latency bound
    map_write(0, 1'b1, 1'b0, 9'h029, 4);
    drive_event(1'b1, 9'h029);
    n = 0; seen = 1'b0; hit = 1'b0;
    for (int i = 0; i < 3 * NK && !hit; i++) begin
      tick();
      n++;
      seen |= bus.busy;
      hit = bus.btn[4];
    end
    check_eq("press_latency", 32'(hit && (n <= NK + 2)), 1);
    check_eq("busy_during_scan", 32'(seen), 1);
    ticks(2 * NK);
    check_eq("busy_after_scan", 32'(bus.busy), 0);
    send(1'b0, 9'h029);
    ticks(NK + 2);
    check_eq("release_btn4", 32'(bus.btn), 0);

    // Extended-bit wildcard vs exact match
    map_write(1, 1'b1, 1'b1, 9'h075, 0);
    send(1'b1, 9'h175);
    ticks(NK + 2);
    check_eq("extwild_press", 32'(bus.btn), 32'h001);
    map_write(1, 1'b1, 1'b0, 9'h075, 0);
    send(1'b0, 9'h175);
    ticks(NK + 2);
    check_eq("exact_no_match", 32'(bus.btn), 32'h001);
    send(1'b0, 9'h075);
    ticks(NK + 2);
    check_eq("exact_release", 32'(bus.btn), 0);

    // Two keys on one button: last event wins
    map_write(2, 1'b1, 1'b0, 9'h014, 4);
    send(1'b1, 9'h029); ticks(NK + 2);
    check_eq("shared_press_a", 32'(bus.btn), 32'h010);
    send(1'b1, 9'h014); ticks(NK + 2);
    check_eq("shared_press_b", 32'(bus.btn), 32'h010);
    send(1'b0, 9'h014); ticks(NK + 2);
    check_eq("shared_release_b", 32'(bus.btn), 0);
    send(1'b0, 9'h029); ticks(NK + 2);

    // Out-of-range target button
    map_write(5, 1'b1, 1'b0, 9'h033, 13);
    send(1'b1, 9'h033); ticks(NK + 2);
    check_eq("out_of_range_btn", 32'(bus.btn), 0);

    // Three back-to-back events: middle one overwritten
    map_write(3, 1'b1, 1'b0, 9'h01C, 2);
    drive_event(1'b1, 9'h029); tick();
    drive_event(1'b1, 9'h01C); tick();
    drive_event(1'b1, 9'h075); tick();
    ticks(2 * NK + 4);
    check_eq("overflow_btn", 32'(bus.btn), 32'h011);
    check_eq("overflow_flag", 32'(bus.overflow), 1);

    // release_all clears next cycle and swallows a coincident event
    bus.release_all = 1'b1;
    tick();
    bus.release_all = 1'b0;
    check_eq("release_all_clear", 32'(bus.btn), 0);
    bus.release_all = 1'b1;
    drive_event(1'b1, 9'h075);
    tick();
    bus.release_all = 1'b0;
    check_eq("release_all_no_scan", 32'(bus.busy), 0);
    ticks(NK + 2);
    check_eq("release_all_drops_event", 32'(bus.btn), 0);
    send(1'b1, 9'h029); ticks(NK + 2);
    check_eq("table_kept", 32'(bus.btn), 32'h010);

    // Stretched button: press then release two cycles later
    map_write(4, 1'b1, 1'b0, 9'h02E, 7);
    drive_event(1'b1, 9'h02E); tick(); tick();
    drive_event(1'b0, 9'h02E);
    rise = 1'b0;
    for (int i = 0; i < 4 * NK && !rise; i++) begin
      tick();
      rise = bus.btn[7];
    end
    check_eq("stretch_rise", 32'(rise), 1);
    hi = 0;
    while (bus.btn[7] && hi < 100) begin
      hi++;
      tick();
    end
    check_eq("stretch_width", 32'(hi), PC);
    ticks(NK + 2);
    check_eq("stretch_end", 32'(bus.btn), 32'h010);

    // Asynchronous reset in the middle of a scan
    drive_event(1'b1, 9'h01C); tick(); tick();
    check_eq("mid_scan_busy", 32'(bus.busy), 1);
    RESET = 1'b1;
    #1;
    check_eq("mid_reset_btn", 32'(bus.btn), 0);
    check_eq("mid_reset_busy", 32'(bus.busy), 0);
    check_eq("mid_reset_overflow", 32'(bus.overflow), 0);
    tick();
    RESET = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= bus.busy;
    end
    check_eq("no_event_after_reset2", 32'(seen), 0);
    drive_event(1'b1, 9'h029);
    seen = 1'b0;
    for (int i = 0; i < NK + 2; i++) begin
      tick();
      seen |= bus.busy;
    end
    check_eq("post_reset_event_seen", 32'(seen), 1);
    check_eq("table_invalid", 32'(bus.btn), 0);

    // Randomized events and table writes against the model
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        map_write($urandom_range(0, NK - 1), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 7)], $urandom_range(0, 15));
      end else if (r == 3) begin
        bus.release_all = 1'b1;
        tick();
        bus.release_all = 1'b0;
        m_state = '0;
        check_eq("rnd_release_all", 32'(bus.btn), 32'(m_state));
      end else begin
        p = 1'($urandom_range(0, 1));
        c = pool[$urandom_range(0, 7)];
        send(p, c);
        model_event(p, c);
        ticks(NK + 25);
        check_eq("rnd_btn", 32'(bus.btn), 32'(m_state));
        check_eq("rnd_busy", 32'(bus.busy), 0);
      end
    end
    check_eq("rnd_no_overflow", 32'(bus.overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
